// File: rtl/caliptra_fdm_ctrl.sv
// caliptra_fdm_ctrl
// Master sequencer for the fuse distribution module. On a start pulse it walks
// NUM_WORDS fuse words. For each word it asks the APB engine to read the word
// from the fuse map, then asks it to write the same data to the matching
// Caliptra fuse register. After the last word it writes 1 to the Caliptra
// fuse-write-done register.
//
// Ports
//   i_clk, i_reset         clock; synchronous active-high reset
//   i_start                start pulse, honoured only in IDLE
//   o_busy/o_done/o_error  status; done and error are sticky
//   o_err_code             1 = slave error, 2 = timeout, 0 = none
//   o_err_index            word index being processed when the error occurred
//   o_apb_en               one-cycle request pulse to the engine
//   o_apb_op               0 = fuse read, 1 = Caliptra write
//   o_src_addr/o_dst_addr  read / write addresses
//   o_apb_sm_wdata         write data
//   i_apb_done             engine completion pulse
//   i_apb_error            slave error, qualified by i_apb_done
//   i_apb_sm_rdata         read data, valid with i_apb_done on a read
//   o_dbg_state            current FSM state, for observation only
//
// Request handshake: o_apb_en is a single-cycle request. While the request is
// outstanding (any *_WAIT state), op, addresses and write data stay frozen and
// o_apb_en stays low. The request is retired by the first i_apb_done seen in
// the wait state. An i_apb_done seen in any other state is dropped.
module caliptra_fdm_ctrl #(
  parameter int                        APB_ADDR_WIDTH  = 32,
  parameter int                        APB_DATA_WIDTH  = 32,
  parameter int                        NUM_WORDS       = 8,
  parameter logic [APB_ADDR_WIDTH-1:0] FUSE_BASE_ADDR  = 32'h0000_0000,
  parameter logic [APB_ADDR_WIDTH-1:0] CPTRA_BASE_ADDR = 32'h0000_0200,
  parameter logic [APB_ADDR_WIDTH-1:0] CPTRA_DONE_ADDR = 32'h0000_02F0,
  parameter int                        TIMEOUT_CYCLES  = 256
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [1:0]                o_err_code,
  output logic [7:0]                o_err_index,
  output logic                      o_apb_en,
  output logic                      o_apb_op,
  output logic [APB_ADDR_WIDTH-1:0] o_src_addr,
  output logic [APB_ADDR_WIDTH-1:0] o_dst_addr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_sm_wdata,
  input  logic                      i_apb_done,
  input  logic                      i_apb_error,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_sm_rdata,
  output logic [3:0]                o_dbg_state
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_REQ  = 4'd1;
  localparam logic [3:0] S_RD_WAIT = 4'd2;
  localparam logic [3:0] S_WR_REQ  = 4'd3;
  localparam logic [3:0] S_WR_WAIT = 4'd4;
  localparam logic [3:0] S_DN_REQ  = 4'd5;
  localparam logic [3:0] S_DN_WAIT = 4'd6;
  localparam logic [3:0] S_FINISH  = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       IDX_LAST = 8'(NUM_WORDS - 1);

  localparam logic [1:0] ERR_SLAVE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  logic [3:0]                state;
  logic [7:0]                idx;
  logic [APB_DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]          tmo_cnt;

  logic [7:0]                idx_inc;
  logic [APB_ADDR_WIDTH-1:0] off_cur;
  logic [APB_ADDR_WIDTH-1:0] off_nxt;
  logic                      in_wait;
  logic                      slv_err;
  logic                      tmo_hit;

  // Word byte offsets; idx*4 is zero-extended into the address width.
  assign idx_inc = idx + 8'd1;
  assign off_cur = APB_ADDR_WIDTH'({idx, 2'b00});
  assign off_nxt = APB_ADDR_WIDTH'({idx_inc, 2'b00});

  assign in_wait = (state == S_RD_WAIT) || (state == S_WR_WAIT) ||
                   (state == S_DN_WAIT);
  assign slv_err = in_wait && i_apb_done && i_apb_error;
  // A done on the last allowed wait cycle wins over the timeout.
  assign tmo_hit = in_wait && !i_apb_done && (tmo_cnt == CNT_LAST);

  assign o_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_IDLE;
      idx            <= 8'd0;
      data_q         <= '0;
      tmo_cnt        <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_err_code     <= 2'd0;
      o_err_index    <= 8'd0;
      o_apb_en       <= 1'b0;
      o_apb_op       <= 1'b0;
      o_src_addr     <= '0;
      o_dst_addr     <= '0;
      o_apb_sm_wdata <= '0;
    end else begin
      // Request strobe is a pulse; it is raised only on entry to a *_REQ state.
      o_apb_en <= 1'b0;
      if (in_wait) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (slv_err || tmo_hit) begin
        state       <= S_ERROR;
        o_busy      <= 1'b0;
        o_error     <= 1'b1;
        o_err_code  <= slv_err ? ERR_SLAVE : ERR_TIMEOUT;
        o_err_index <= idx;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              o_done      <= 1'b0;
              o_error     <= 1'b0;
              o_err_code  <= 2'd0;
              o_err_index <= 8'd0;
              o_busy      <= 1'b1;
              idx         <= 8'd0;
              o_apb_en    <= 1'b1;
              o_apb_op    <= 1'b0;
              o_src_addr  <= FUSE_BASE_ADDR;
              tmo_cnt     <= '0;
              state       <= S_RD_REQ;
            end
          end
          S_RD_REQ: state <= S_RD_WAIT;
          S_RD_WAIT: begin
            if (i_apb_done) begin
              // Write data is loaded from the engine directly so it is already
              // valid during the write request cycle.
              data_q         <= i_apb_sm_rdata;
              o_apb_sm_wdata <= i_apb_sm_rdata;
              o_apb_en       <= 1'b1;
              o_apb_op       <= 1'b1;
              o_dst_addr     <= CPTRA_BASE_ADDR + off_cur;
              tmo_cnt        <= '0;
              state          <= S_WR_REQ;
            end
          end
          S_WR_REQ: state <= S_WR_WAIT;
          S_WR_WAIT: begin
            if (i_apb_done) begin
              o_apb_en <= 1'b1;
              tmo_cnt  <= '0;
              if (idx == IDX_LAST) begin
                o_apb_op       <= 1'b1;
                o_dst_addr     <= CPTRA_DONE_ADDR;
                o_apb_sm_wdata <= APB_DATA_WIDTH'(1);
                state          <= S_DN_REQ;
              end else begin
                idx        <= idx_inc;
                o_apb_op   <= 1'b0;
                o_src_addr <= FUSE_BASE_ADDR + off_nxt;
                state      <= S_RD_REQ;
              end
            end
          end
          S_DN_REQ: state <= S_DN_WAIT;
          S_DN_WAIT: begin
            if (i_apb_done) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= S_FINISH;
            end
          end
          S_FINISH: state <= S_IDLE;
          S_ERROR:  state <= S_ERROR;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_caliptra_fdm_ctrl.sv
// Bench for caliptra_fdm_ctrl: a behavioural APB engine answers the requests,
// a reference model lists the engine requests a scenario should produce, and a
// monitor checks every o_apb_en pulse against that list.
module tb_caliptra_fdm_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 8;
  localparam int TO = 256;
  localparam logic [AW-1:0] FUSE_BASE  = 32'h0000_0000;
  localparam logic [AW-1:0] CPTRA_BASE = 32'h0000_0200;
  localparam logic [AW-1:0] DONE_ADDR  = 32'h0000_02F0;
  localparam int W = 1 + AW + DW;
  localparam int MAX_WAIT = 5000;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_start = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          o_busy, o_done, o_error, o_apb_en, o_apb_op;
  logic [1:0]    o_err_code;
  logic [7:0]    o_err_index;
  logic [AW-1:0] o_src_addr, o_dst_addr;
  logic [DW-1:0] o_apb_sm_wdata;
  logic          i_apb_done, i_apb_error;
  logic [DW-1:0] i_apb_sm_rdata;
  logic [3:0]    o_dbg_state;

  caliptra_fdm_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_code(o_err_code), .o_err_index(o_err_index),
    .o_apb_en(o_apb_en), .o_apb_op(o_apb_op),
    .o_src_addr(o_src_addr), .o_dst_addr(o_dst_addr),
    .o_apb_sm_wdata(o_apb_sm_wdata),
    .i_apb_done(i_apb_done), .i_apb_error(i_apb_error),
    .i_apb_sm_rdata(i_apb_sm_rdata), .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // scenario knobs, written only by the stimulus process
  logic [DW-1:0] rdata_mem [NW];
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic          hang_en = 1'b0;
  logic [AW-1:0] hang_addr = '0;
  logic          slow_en = 1'b0;
  logic [AW-1:0] slow_addr = '0;
  int            slow_lat = 1;
  int            spur_req = 0;

  // observation counters, written only by the monitor / cycle counter
  int cyc = 0;
  int en_count = 0;
  int en_cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the engine requests a scenario must produce, in order,
  // plus the final status. Reads carry no data (packed as 0).
  task automatic build_expect(output logic [1:0] code, output logic [7:0] eidx);
    logic [AW-1:0] ra, wa;
    code = 2'd0;
    eidx = 8'd0;
    for (int i = 0; i < NW; i++) begin
      ra = FUSE_BASE + AW'(i * 4);
      wa = CPTRA_BASE + AW'(i * 4);
      exp_q.push_back({1'b0, ra, {DW{1'b0}}});
      if (hang_en && ra == hang_addr) begin code = 2'd2; eidx = 8'(i); return; end
      if (err_en && ra == err_addr)   begin code = 2'd1; eidx = 8'(i); return; end
      exp_q.push_back({1'b1, wa, rdata_mem[i]});
      if (hang_en && wa == hang_addr) begin code = 2'd2; eidx = 8'(i); return; end
      if (err_en && wa == err_addr)   begin code = 2'd1; eidx = 8'(i); return; end
    end
    exp_q.push_back({1'b1, DONE_ADDR, DW'(1)});
    if (hang_en && DONE_ADDR == hang_addr) begin code = 2'd2; eidx = 8'(NW - 1); end
    else if (err_en && DONE_ADDR == err_addr) begin code = 2'd1; eidx = 8'(NW - 1); end
  endtask

  // monitor: every request pulse is popped against the expected queue
  initial begin : monitor
    logic prev_en;
    logic [W-1:0] got;
    prev_en = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        prev_en = 1'b0;
      end else begin
        if (o_apb_en) begin
          en_count++;
          en_cyc = cyc;
          check("en_back_to_back", prev_en, 0);
          got = {o_apb_op, o_apb_op ? o_dst_addr : o_src_addr,
                 o_apb_op ? o_apb_sm_wdata : {DW{1'b0}}};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got %0h expected none", got);
          end else begin
            check("apb_req", got, exp_q.pop_front());
          end
        end
        prev_en = o_apb_en;
      end
    end
  end

  // behavioural APB engine
  initial begin : engine
    int lat;
    int spur_seen;
    bit aborted, hanging;
    logic [AW-1:0] a;
    logic [1+3*32-1:0] snap;
    spur_seen = 0;
    i_apb_done = 1'b0;
    i_apb_error = 1'b0;
    i_apb_sm_rdata = '0;
    forever begin
      @(negedge i_clk);
      i_apb_done = 1'b0;
      i_apb_error = 1'b0;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        i_apb_done = 1'b1;
        i_apb_sm_rdata = $urandom;
      end else if (!i_reset && o_apb_en) begin
        a = o_apb_op ? o_dst_addr : o_src_addr;
        snap = {o_apb_op, o_src_addr, o_dst_addr, o_apb_sm_wdata};
        hanging = hang_en && (a == hang_addr);
        if (hanging) lat = TO + 50;
        else if (slow_en && a == slow_addr) lat = slow_lat;
        else lat = $urandom_range(1, 4);
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge i_clk);
          if (i_reset || o_error) begin aborted = 1'b1; break; end
          check("req_hold", {o_apb_op, o_src_addr, o_dst_addr, o_apb_sm_wdata}, snap);
          check("en_outstanding", o_apb_en, 0);
        end
        if (!aborted && !hanging) begin
          i_apb_done = 1'b1;
          i_apb_error = err_en && (a == err_addr);
          if (!snap[96] && (a - FUSE_BASE) < AW'(NW * 4))
            i_apb_sm_rdata = rdata_mem[(a - FUSE_BASE) >> 2];
          else
            i_apb_sm_rdata = $urandom;
        end
      end
    end
  end

  // driver tasks
  task automatic clear_scenario();
    err_en = 1'b0;
    hang_en = 1'b0;
    slow_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_start = 1'b0;
    @(negedge i_clk);
    check("reset_outputs", {o_busy, o_done, o_error, o_err_code, o_err_index, o_apb_en,
                            o_apb_op, o_src_addr, o_dst_addr, o_apb_sm_wdata, o_dbg_state}, 0);
    exp_q.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic run_seq(input string name);
    logic [1:0] ecode;
    logic [7:0] eidx;
    bit seen;
    build_expect(ecode, eidx);
    @(negedge i_clk);
    i_start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < MAX_WAIT; c++) begin
      @(negedge i_clk);
      if (o_done || o_error) begin seen = 1'b1; break; end
      i_start = ($urandom_range(0, 7) == 0);  // starts while busy must be ignored
    end
    i_start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_complete: got no done/error expected one within %0d cycles", name, MAX_WAIT);
    end
    check({name, "_status"}, {o_busy, o_done, o_error, o_err_code, o_err_index},
          {1'b0, ecode == 2'd0, ecode != 2'd0, ecode, eidx});
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic set_nominal_data();
    for (int i = 0; i < NW; i++) rdata_mem[i] = 32'hA5A5_0000 + DW'(i);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int sel, r;
    set_nominal_data();
    clear_scenario();
    do_reset();

    // spurious done in IDLE must not start anything
    spur_req++;
    repeat (8) @(negedge i_clk);
    check("spurious_idle_busy", {o_busy, o_done, o_error}, 0);

    // nominal
    run_seq("nominal");

    // read slave error on idx 3, then a start in ERROR is ignored
    do_reset();
    err_en = 1'b1;
    err_addr = FUSE_BASE + 32'h0C;
    run_seq("rd_err");
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    check("rd_err_sticky", {o_busy, o_error, o_err_code, o_err_index}, {1'b0, 1'b1, 2'd1, 8'd3});

    // slave error on the done-register write
    clear_scenario();
    do_reset();
    err_en = 1'b1;
    err_addr = DONE_ADDR;
    run_seq("dn_err");

    // engine never answers the first read
    clear_scenario();
    do_reset();
    hang_en = 1'b1;
    hang_addr = FUSE_BASE;
    base = en_count;
    run_seq("timeout");
    check("timeout_latency", cyc - en_cyc, TO + 1);
    check("timeout_en_pulses", en_count - base, 1);

    // done on the last allowed wait cycle is honoured
    clear_scenario();
    do_reset();
    slow_en = 1'b1;
    slow_addr = FUSE_BASE;
    slow_lat = TO;
    run_seq("timeout_edge");

    // reset during WR_WAIT of idx 5, then a clean restart from 0x00
    clear_scenario();
    do_reset();
    slow_en = 1'b1;
    slow_addr = CPTRA_BASE + 32'h14;
    slow_lat = 40;
    begin
      logic [1:0] c;
      logic [7:0] ix;
      build_expect(c, ix);
    end
    base = en_count;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c < MAX_WAIT; c++) begin
      if (en_count - base >= 12) break;
      @(negedge i_clk);
    end
    check("mid_reset_reached_wr5", en_count - base, 12);
    repeat (3) @(negedge i_clk);
    do_reset();
    clear_scenario();
    run_seq("restart");

    // randomized scenarios
    for (int t = 0; t < 8; t++) begin
      clear_scenario();
      do_reset();
      for (int i = 0; i < NW; i++) rdata_mem[i] = $urandom;
      sel = $urandom_range(0, 3);
      r = $urandom_range(0, NW - 1);
      if (sel == 1) begin err_en = 1'b1; err_addr = FUSE_BASE + AW'(r * 4); end
      if (sel == 2) begin err_en = 1'b1; err_addr = CPTRA_BASE + AW'(r * 4); end
      if (sel == 3) begin err_en = 1'b1; err_addr = DONE_ADDR; end
      run_seq("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/caliptra_fdm_ctrl.md
Name: caliptra_fdm_ctrl

Overview:
Master sequencer for the fuse distribution module; sits directly upstream of the FDM APB engine and drives its request interface.
- On start, walks NUM_WORDS fuse words. For each word, it commands an engine read from the fuse map, captures the returned data, then commands an engine write of that data to the matching Caliptra fuse register.
- After the last word, it writes a completion value to a Caliptra done register.
- It reports busy, done and error status to the wrapper.

Parameters:
- APB_ADDR_WIDTH, 32, engine address width.
- APB_DATA_WIDTH, 32, engine data width.
- NUM_WORDS, 8, fuse words to transfer; legal range 2..256.
- FUSE_BASE_ADDR, 32'h0000_0000, fuse-map address of word 0.
- CPTRA_BASE_ADDR, 32'h0000_0200, Caliptra fuse register address of word 0.
- CPTRA_DONE_ADDR, 32'h0000_02F0, Caliptra fuse-write-done register.
- TIMEOUT_CYCLES, 256, maximum wait cycles per engine request; must be at least 4.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset. One clock; reset is synchronous and active-high.
- i_start  in  1  start pulse; honoured only in IDLE.
- o_busy  out  1  sequence in progress.
- o_done  out  1  sticky; the sequence completed without error.
- o_error  out  1  sticky; the sequence aborted.
- o_err_code  out  2  error cause: 1 = slave error, 2 = timeout, 0 = none.
- o_err_index  out  8  word index being processed when the error occurred.
- o_apb_en  out  1  one-cycle request pulse to the engine.
- o_apb_op  out  1  0 = fuse read, 1 = Caliptra write.
- o_src_addr  out  APB_ADDR_WIDTH  fuse read address.
- o_dst_addr  out  APB_ADDR_WIDTH  Caliptra write address.
- o_apb_sm_wdata  out  APB_DATA_WIDTH  write data.
- i_apb_done  in  1  engine completion pulse.
- i_apb_error  in  1  engine slave error, qualified by i_apb_done.
- i_apb_sm_rdata  in  APB_DATA_WIDTH  read data, valid with i_apb_done on a read.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; idx 0; data register 0; timeout counter 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DN_REQ, DN_WAIT, FINISH, ERROR.
- IDLE: when i_start=1, clear o_done, o_error, o_err_code and o_err_index; set idx=0 and o_busy=1; go to RD_REQ.
- RD_REQ, lasting 1 cycle:
  - o_apb_en=1 for exactly this cycle; o_apb_op=0.
  - o_src_addr = FUSE_BASE_ADDR + idx*4.
  - Go to RD_WAIT.
- RD_WAIT: o_apb_op and the addresses are held stable. On i_apb_done:
  - If i_apb_error=1, go to ERROR with code 1.
  - Otherwise latch i_apb_sm_rdata into the data register and go to WR_REQ.
- WR_REQ, lasting 1 cycle:
  - o_apb_en=1; o_apb_op=1.
  - o_dst_addr = CPTRA_BASE_ADDR + idx*4.
  - o_apb_sm_wdata = the data register.
  - Go to WR_WAIT.
- WR_WAIT: o_apb_op, o_dst_addr and o_apb_sm_wdata are held until i_apb_done. On i_apb_done:
  - If i_apb_error=1, go to ERROR with code 1.
  - Else if idx == NUM_WORDS-1, go to DN_REQ.
  - Otherwise idx++ and go to RD_REQ.
- DN_REQ / DN_WAIT: same as WR_REQ / WR_WAIT, but with o_dst_addr=CPTRA_DONE_ADDR and o_apb_sm_wdata=1. On a clean done, go to FINISH; on error, go to ERROR with code 1.
- FINISH, lasting 1 cycle: o_busy=0, o_done=1; return to IDLE. o_done stays 1 until the next accepted start.
- ERROR: o_busy=0, o_error=1, o_err_index=idx. The block stays in ERROR until reset; i_start is ignored.
- Timeout:
  - The counter clears on entry to every *_REQ state and increments in every *_WAIT state.
  - Reaching TIMEOUT_CYCLES without i_apb_done goes to ERROR with code 2.
  - i_apb_done in the same cycle as the limit takes priority: no timeout.
- o_apb_en is never 1 in two consecutive cycles and is never asserted while a request is outstanding. This prevents the engine from restarting on its IDLE sample.
- An i_apb_done arriving in IDLE, FINISH, ERROR or any *_REQ state is ignored.
- Reset mid-sequence returns to IDLE immediately with all outputs 0. The engine is reset by the same wrapper reset.
- Address arithmetic is modulo 2^APB_ADDR_WIDTH; idx*4 is zero-extended.
- Minimum sequence latency, with the engine completing each request in 3 cycles: NUM_WORDS*8 + 6 cycles from start to o_done.

Test Plan:
- Nominal: NUM_WORDS=8; engine model returns rdata 32'hA5A5_0000+idx, no errors. Required response:
  - Reads at 0x00..0x1C.
  - Writes of the matching data to 0x200..0x21C.
  - Final write of 1 to 0x2F0.
  - o_done=1, o_busy=0, o_error=0.
- Read slave error on idx=3 → no write to 0x20C; o_error=1, o_err_code=1, o_err_index=3; a later i_start is ignored.
- Write slave error on the done-register write → o_error=1, o_err_code=1, o_err_index=7, o_done=0.
- Engine never returns done on idx=0 read → o_error=1 and o_err_code=2 after 256 wait cycles; exactly one o_apb_en pulse seen.
- i_reset asserted during WR_WAIT of idx=5 → next cycle all outputs 0, state IDLE. A new i_start then restarts from address 0x00.
- Protocol check across all tests:
  - o_apb_en is never high on consecutive cycles.
  - o_apb_op and the addresses are stable from request to done.
  - i_start pulses while busy are ignored.
  - A spurious i_apb_done in IDLE causes no transfer.
